// File: rtl/micro_seq_if.sv
// Sequencer bus: decoder/control-store side (master) drives ops and addresses,
// the sequencer (slave) returns the current micro-address and stack status.
interface micro_seq_if #(
  parameter int AW    = 16,
  parameter int DEPTH = 4
) ();
  localparam int SPW = $clog2(DEPTH + 1);

  logic           en;
  logic [2:0]     seq_op;
  logic [AW-1:0]  map_addr;
  logic [AW-1:0]  next_addr;
  logic           cond;
  logic [AW-1:0]  upc_out;
  logic [SPW-1:0] sp_out;
  logic           stack_ovf;
  logic           stack_unf;

  modport master (
    output en, seq_op, map_addr, next_addr, cond,
    input  upc_out, sp_out, stack_ovf, stack_unf
  );

  modport slave (
    input  en, seq_op, map_addr, next_addr, cond,
    output upc_out, sp_out, stack_ovf, stack_unf
  );
endinterface

// File: rtl/micro_seq.sv
// Micro-program sequencer: next-address selection plus an optional bounded
// return-address stack, built only when MICRO_SEQ_STACK_EN is defined.
module micro_seq #(
  parameter int AW    = 16,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  micro_seq_if.slave sif
);
  localparam int SPW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    OP_HOLD    = 3'b000,
    OP_INC     = 3'b001,
    OP_JMP     = 3'b010,
    OP_MAP     = 3'b011,
    OP_CJMP    = 3'b100,
    OP_CALL    = 3'b101,
    OP_RET     = 3'b110,
    OP_RESTART = 3'b111
  } seq_op_e;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return a + AW'(1);
  endfunction

  seq_op_e       op;
  logic [AW-1:0] upc_q, upc_d;

  assign op = seq_op_e'(sif.seq_op);

`ifdef MICRO_SEQ_STACK_EN
  // Stack index width; one bit minimum so DEPTH=1 still has a legal index.
  localparam int SIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [SPW-1:0] sp_q, sp_d, sp_m1;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [AW-1:0]  stack_q [0:(2**SIW)-1];
  logic           push;
  logic [SIW-1:0] push_idx, top_idx;
  logic           full, empty;

  assign full     = (sp_q == SPW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign sp_m1    = sp_q - SPW'(1);
  assign push_idx = sp_q[SIW-1:0];
  assign top_idx  = sp_m1[SIW-1:0];

  always_comb begin
    upc_d = upc_q;
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (sif.en) begin
      case (op)
        OP_HOLD: upc_d = upc_q;
        OP_INC:  upc_d = addr_inc(upc_q);
        OP_JMP:  upc_d = sif.next_addr;
        OP_MAP:  upc_d = sif.map_addr;
        OP_CJMP: upc_d = sif.cond ? sif.next_addr : addr_inc(upc_q);
        OP_CALL: begin
          if (!full) begin
            push  = 1'b1;
            sp_d  = sp_q + SPW'(1);
            upc_d = sif.next_addr;
          end else begin
            ovf_d = 1'b1;
          end
        end
        OP_RET: begin
          if (!empty) begin
            upc_d = stack_q[top_idx];
            sp_d  = sp_m1;
          end else begin
            upc_d = '0;
            unf_d = 1'b1;
          end
        end
        OP_RESTART: begin
          upc_d = '0;
          sp_d  = '0;
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
        default: upc_d = upc_q;
      endcase
    end
  end

  // Register stage: control state is reset, stack storage is not.
  always_ff @(posedge clk) begin
    if (rst) begin
      upc_q <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      upc_q <= upc_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[push_idx] <= addr_inc(upc_q);
    end
  end

  assign sif.sp_out    = sp_q;
  assign sif.stack_ovf = ovf_q;
  assign sif.stack_unf = unf_q;
`else
  // Without a stack, CALL degenerates to JMP and RET to RESTART.
  always_comb begin
    upc_d = upc_q;
    if (sif.en) begin
      case (op)
        OP_HOLD:    upc_d = upc_q;
        OP_INC:     upc_d = addr_inc(upc_q);
        OP_JMP:     upc_d = sif.next_addr;
        OP_MAP:     upc_d = sif.map_addr;
        OP_CJMP:    upc_d = sif.cond ? sif.next_addr : addr_inc(upc_q);
        OP_CALL:    upc_d = sif.next_addr;
        OP_RET:     upc_d = '0;
        OP_RESTART: upc_d = '0;
        default:    upc_d = upc_q;
      endcase
    end
  end

  // Register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      upc_q <= '0;
    end else begin
      upc_q <= upc_d;
    end
  end

  assign sif.sp_out    = '0;
  assign sif.stack_ovf = 1'b0;
  assign sif.stack_unf = 1'b0;
`endif

  assign sif.upc_out = upc_q;

endmodule

// File: tb/tb_micro_seq.sv
// Directed bench for micro_seq; expectations adapt to whether
// MICRO_SEQ_STACK_EN is defined for the build.
module tb_micro_seq;
`ifdef MICRO_SEQ_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  localparam logic [2:0] HOLD = 3'b000, INC = 3'b001, JMP = 3'b010, MAP = 3'b011;
  localparam logic [2:0] CJMP = 3'b100, CALL = 3'b101, RET = 3'b110, RESTART = 3'b111;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  micro_seq_if #(.AW(16), .DEPTH(4)) bus ();

  micro_seq #(.AW(16), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .sif (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input logic e, input logic [2:0] op, input logic [15:0] na,
                      input logic [15:0] ma, input logic c);
    bus.en        = e;
    bus.seq_op    = op;
    bus.next_addr = na;
    bus.map_addr  = ma;
    bus.cond      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] upc, input logic [2:0] sp,
                           input logic ovf, input logic unf);
    check({tag, ".upc"}, 32'(bus.upc_out), 32'(upc));
    check({tag, ".sp"},  32'(bus.sp_out),  32'(sp));
    check({tag, ".ovf"}, 32'(bus.stack_ovf), 32'(ovf));
    check({tag, ".unf"}, 32'(bus.stack_unf), 32'(unf));
  endtask

  initial begin
    rst = 1'b1;
    step(1'b1, CALL, 16'h1234, 16'h0000, 1'b0);
    step(1'b1, CALL, 16'h1234, 16'h0000, 1'b0);
    rst = 1'b0;
    check_all("reset", 16'h0000, 3'd0, 1'b0, 1'b0);

    step(1'b1, INC, 16'h0, 16'h0, 1'b0);  check("inc1", 32'(bus.upc_out), 32'h1);
    step(1'b1, INC, 16'h0, 16'h0, 1'b0);  check("inc2", 32'(bus.upc_out), 32'h2);
    step(1'b1, INC, 16'h0, 16'h0, 1'b0);  check("inc3", 32'(bus.upc_out), 32'h3);
    step(1'b0, INC, 16'h0, 16'h0, 1'b0);  check("en0_a", 32'(bus.upc_out), 32'h3);
    step(1'b0, JMP, 16'h7777, 16'h0, 1'b1); check("en0_b", 32'(bus.upc_out), 32'h3);

    step(1'b1, JMP, 16'hFFFF, 16'h0, 1'b0); check("jmp_ffff", 32'(bus.upc_out), 32'hFFFF);
    step(1'b1, INC, 16'h0, 16'h0, 1'b0);    check("inc_wrap", 32'(bus.upc_out), 32'h0);

    step(1'b1, MAP,  16'h0, 16'h0040, 1'b0); check("map", 32'(bus.upc_out), 32'h0040);
    step(1'b1, CJMP, 16'h0100, 16'h0, 1'b0); check("cjmp_c0", 32'(bus.upc_out), 32'h0041);
    step(1'b1, CJMP, 16'h0100, 16'h0, 1'b1); check("cjmp_c1", 32'(bus.upc_out), 32'h0100);
    step(1'b1, HOLD, 16'h0200, 16'h0300, 1'b1); check("hold", 32'(bus.upc_out), 32'h0100);

    // Nested calls
    step(1'b1, JMP,  16'h0010, 16'h0, 1'b0); check("jmp10", 32'(bus.upc_out), 32'h0010);
    step(1'b1, CALL, 16'h0200, 16'h0, 1'b0);
    check_all("call1", 16'h0200, STK ? 3'd1 : 3'd0, 1'b0, 1'b0);
    step(1'b1, CALL, 16'h0300, 16'h0, 1'b0);
    check_all("call2", 16'h0300, STK ? 3'd2 : 3'd0, 1'b0, 1'b0);
    step(1'b0, RET, 16'h0, 16'h0, 1'b0);
    check_all("en0_ret", 16'h0300, STK ? 3'd2 : 3'd0, 1'b0, 1'b0);
    step(1'b1, RET, 16'h0, 16'h0, 1'b0);
    check_all("ret1", STK ? 16'h0201 : 16'h0000, STK ? 3'd1 : 3'd0, 1'b0, 1'b0);
    step(1'b1, RET, 16'h0, 16'h0, 1'b0);
    check_all("ret2", STK ? 16'h0011 : 16'h0000, 3'd0, 1'b0, 1'b0);

    // Stack boundaries: five calls then five returns
    step(1'b1, CALL, 16'h1000, 16'h0, 1'b0);
    step(1'b1, CALL, 16'h2000, 16'h0, 1'b0);
    step(1'b1, CALL, 16'h3000, 16'h0, 1'b0);
    step(1'b1, CALL, 16'h4000, 16'h0, 1'b0);
    check_all("call4", 16'h4000, STK ? 3'd4 : 3'd0, 1'b0, 1'b0);
    step(1'b1, CALL, 16'h5000, 16'h0, 1'b0);
    check_all("call5_ovf", STK ? 16'h4000 : 16'h5000, STK ? 3'd4 : 3'd0, STK, 1'b0);
    step(1'b1, RET, 16'h0, 16'h0, 1'b0);
    check_all("bret1", STK ? 16'h3001 : 16'h0000, STK ? 3'd3 : 3'd0, STK, 1'b0);
    step(1'b1, RET, 16'h0, 16'h0, 1'b0);
    check("bret2", 32'(bus.upc_out), STK ? 32'h2001 : 32'h0);
    step(1'b1, RET, 16'h0, 16'h0, 1'b0);
    check("bret3", 32'(bus.upc_out), STK ? 32'h1001 : 32'h0);
    step(1'b1, RET, 16'h0, 16'h0, 1'b0);
    check_all("bret4", STK ? 16'h0012 : 16'h0000, 3'd0, STK, 1'b0);
    step(1'b1, RET, 16'h0, 16'h0, 1'b0);
    check_all("bret5_unf", 16'h0000, 3'd0, STK, STK);
    step(1'b1, INC, 16'h0, 16'h0, 1'b0);
    check_all("flags_sticky", 16'h0001, 3'd0, STK, STK);
    step(1'b1, RESTART, 16'h0, 16'h0, 1'b0);
    check_all("restart", 16'h0000, 3'd0, 1'b0, 1'b0);

    // Reset in the middle of a subroutine, together with a CALL
    step(1'b1, CALL, 16'h0200, 16'h0, 1'b0);
    step(1'b1, CALL, 16'h0300, 16'h0, 1'b0);
    check_all("pre_rst", 16'h0300, STK ? 3'd2 : 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, CALL, 16'h0400, 16'h0, 1'b0);
    rst = 1'b0;
    check_all("mid_rst", 16'h0000, 3'd0, 1'b0, 1'b0);

    // Call then immediate return lands on call-site+1
    step(1'b1, CALL, 16'h0500, 16'h0, 1'b0);
    check("bb_call", 32'(bus.upc_out), 32'h0500);
    step(1'b1, RET, 16'h0, 16'h0, 1'b0);
    check_all("bb_ret", STK ? 16'h0001 : 16'h0000, 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
